ifu_prefetch: RTL and testbench
===============================

Name: ifu_prefetch

Overview:
- Parametrised next-generation instruction fetch unit: decouples PC generation from execution with an in-order prefetch FIFO.
- Issues word fetches to the instruction SRAM over a valid/ready request channel and accepts in-order responses with arbitrary latency.
- Presents {pc, instr} to EXU with valid/ready backpressure (replaces hold).
- On a jump, it redirects and discards in-flight responses.

Parameters:
- XLEN, 32, instruction/address width.
- FIFO_DEPTH, 4, prefetch entries; power of two, at least 2.
- MAX_OUTSTANDING, 2, maximum in-flight SRAM requests; at least 1.
- RESET_PC, 32'h0000_0000, fetch address after reset.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- mem_req_valid_o  out  1  fetch request valid.
- mem_req_ready_i  in  1  SRAM accepts request.
- mem_req_addr_o  out  XLEN  word-aligned fetch address.
- mem_rsp_valid_i  in  1  response valid; responses are in order and cannot be stalled.
- mem_rsp_data_i  in  XLEN  fetched instruction.
- jump_valid_i  in  1  redirect request from EXU.
- pc_next_i  in  XLEN  redirect target.
- instr_valid_o  out  1  FIFO head valid.
- instr_ready_i  in  1  EXU consumes head.
- instr_o  out  XLEN  head instruction; NOP when not valid.
- instr_pc_o  out  XLEN  PC of head instruction.

Behaviour:
- Reset is rst_n, asynchronous, active-low; clock is clk. Reset takes effect mid-operation too: the FIFO and all counters clear, and in-flight responses are not tracked. The SRAM is reset together with this block.
- Reset values:
  - fetch_pc and rsp_pc = RESET_PC.
  - FIFO empty.
  - outstanding = 0, discard = 0.
  - instr_valid_o = 0, instr_o = NOP (32'h0000_0013), instr_pc_o = RESET_PC.
- Definitions:
  - live = outstanding - discard.
  - Counters are $clog2(MAX(FIFO_DEPTH, MAX_OUTSTANDING)+1) bits wide.
- Issue rule: mem_req_valid_o = (fifo_count + live < FIFO_DEPTH) && (outstanding < MAX_OUTSTANDING). It depends on registered state only and is first high in the first cycle after reset release.
  - mem_req_addr_o = fetch_pc.
  - A handshake (valid & ready) increments fetch_pc by 4 (modulo 2^XLEN, wraps silently) and outstanding by 1.
- Response rule: each mem_rsp_valid_i decrements outstanding.
  - If discard > 0: the response is dropped and discard decrements.
  - Otherwise: {rsp_pc, data} is pushed into the FIFO and rsp_pc += 4.
  - The credit rule guarantees the FIFO never overflows; an overflow is an assertion failure.
- Output: the head is registered. A push into an empty FIFO in cycle N gives instr_valid_o = 1 in cycle N+1.
  - A pop occurs on instr_valid_o & instr_ready_i.
  - Push and pop in the same cycle keep the count unchanged, including when the FIFO is full.
  - With instr_ready_i low, the head and instr_valid_o stay stable.
- Jump (highest priority in a cycle):
  - fetch_pc and rsp_pc <= pc_next_i.
  - The FIFO is cleared; any same-cycle push or pop is void.
  - discard <= outstanding value after this cycle's request/response events. A response arriving in the jump cycle is dropped and not counted.
  - instr_valid_o = 0 in the next cycle.
  - A request in progress (valid, not ready) may change address on the cycle after a jump; the SRAM port tolerates withdrawal.
- Back-to-back jumps: the latest target wins; discard is recomputed each time.
- Throughput: with a zero-wait SRAM (1-cycle response) and instr_ready_i held high, one instruction is delivered per cycle at steady state.

Optional Feature:
- IFU_MISALIGN_CHK_EN adds output misalign_exc_o (1 bit, reset 0).
- With the macro defined, a jump with pc_next_i[1:0] != 0:
  - performs no redirect and issues no fetches;
  - flushes the FIFO;
  - sets misalign_exc_o = 1 (sticky) until the next valid aligned jump.
- Without the macro: no port; bits [1:0] of pc_next_i are forced to 0.

Decomposition:
- Shared package/define file:
  - NOP encoding 32'h0000_0013.
  - Default RESET_PC.
  - Instruction width constant.
  - A packed {pc, instr} FIFO entry typedef.
- One natural sub-module: ifu_fifo. It is a synchronous circular FIFO parametrised by width/depth with push, pop, clear, count, full and empty. clear has priority over push and pop.

Test Plan:
- Reset release, SRAM ready=1, 1-cycle response, instr_ready=1: expected behaviour:
  - addresses 0x0, 0x4, 0x8 issue on consecutive cycles;
  - instr_pc_o 0x0, 0x4, 0x8 appear one per cycle;
  - instr_o = returned data.
- instr_ready=0 for 10 cycles:
  - the FIFO fills to FIFO_DEPTH=4 and mem_req_valid_o drops;
  - the head stays at pc 0x0;
  - after release, pcs 0x0–0xC then 0x10 follow without gaps or loss.
- 3-cycle response latency with MAX_OUTSTANDING=2: no more than 2 requests are in flight; delivery order is preserved.
- Jump to 0x100 with 2 responses in flight: both responses are dropped; the next instr_pc_o = 0x100 with the data fetched from 0x100.
- Jump in the same cycle as a response and a pop, then a second jump to 0x200 the next cycle: only pc 0x200 and onward is delivered.
- With IFU_MISALIGN_CHK_EN, jump to 0x102: misalign_exc_o = 1, FIFO empty, no requests; then jump to 0x200 clears the flag and fetch resumes.

Source files
------------

// File: rtl/ifu_prefetch_pkg.sv
// Shared constants and types for the instruction prefetch unit.
package ifu_prefetch_pkg;

  localparam int INSTR_W = 32;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [INSTR_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [INSTR_W-1:0] pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ifu_prefetch_if.sv
// Fetch-side bundle: SRAM request/response, EXU redirect and EXU instruction handshake.
interface ifu_prefetch_if #(
  parameter int XLEN = 32
);
  logic            mem_req_valid_o;
  logic            mem_req_ready_i;
  logic [XLEN-1:0] mem_req_addr_o;
  logic            mem_rsp_valid_i;
  logic [XLEN-1:0] mem_rsp_data_i;
  logic            jump_valid_i;
  logic [XLEN-1:0] pc_next_i;
  logic            instr_valid_o;
  logic            instr_ready_i;
  logic [XLEN-1:0] instr_o;
  logic [XLEN-1:0] instr_pc_o;

  modport master (
    output mem_req_valid_o, mem_req_addr_o, instr_valid_o, instr_o, instr_pc_o,
    input  mem_req_ready_i, mem_rsp_valid_i, mem_rsp_data_i, jump_valid_i, pc_next_i,
           instr_ready_i
  );

  modport slave (
    input  mem_req_valid_o, mem_req_addr_o, instr_valid_o, instr_o, instr_pc_o,
    output mem_req_ready_i, mem_rsp_valid_i, mem_rsp_data_i, jump_valid_i, pc_next_i,
           instr_ready_i
  );
endinterface

// File: rtl/ifu_fifo.sv
// Synchronous circular FIFO; clear overrides push and pop, push is allowed when full if a pop occurs.
module ifu_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= wdata;
  end

  // The fetch credit scheme must make a dropped push impossible.
  no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !clear && full && !do_pop));

endmodule

// File: rtl/ifu_prefetch.sv
// Instruction prefetch unit: credit-limited SRAM fetch into an in-order FIFO, redirect on jump.
// Build option IFU_MISALIGN_CHK_EN adds misalign_exc_o and rejects jumps to unaligned targets.
module ifu_prefetch
  import ifu_prefetch_pkg::*;
#(
  parameter int              XLEN            = INSTR_W,
  parameter int              FIFO_DEPTH      = 4,
  parameter int              MAX_OUTSTANDING = 2,
  parameter logic [XLEN-1:0] RESET_PC        = XLEN'(DEFAULT_RESET_PC)
) (
  input  logic           clk,
  input  logic           rst_n,
  ifu_prefetch_if.master bus
`ifdef IFU_MISALIGN_CHK_EN
  , output logic         misalign_exc_o
`endif
);
  localparam int CNT_W = $clog2(max_int(FIFO_DEPTH, MAX_OUTSTANDING) + 1);
  localparam int EW    = 2 * XLEN;

  logic [XLEN-1:0]  fetch_pc;
  logic [XLEN-1:0]  rsp_pc;
  logic [CNT_W-1:0] outstanding;
  logic [CNT_W-1:0] discard;
  logic [CNT_W-1:0] out_nxt;
  logic [CNT_W-1:0] fifo_count;
  logic [CNT_W:0]   credit_used;
  logic [EW-1:0]    head;
  logic [XLEN-1:0]  jump_tgt;
  logic             jump_ok;
  logic             jump_bad;
  logic             fetch_block;
  logic             req_hs;
  logic             rsp_push;
  logic             fifo_empty;
  logic             unused_fifo_full;

`ifdef IFU_MISALIGN_CHK_EN
  assign jump_bad    = bus.jump_valid_i && (bus.pc_next_i[1:0] != 2'b00);
  assign jump_tgt    = bus.pc_next_i;
  assign fetch_block = misalign_exc_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                misalign_exc_o <= 1'b0;
    else if (bus.jump_valid_i) misalign_exc_o <= jump_bad;
  end
`else
  logic unused_pc_lsb;
  assign unused_pc_lsb = ^bus.pc_next_i[1:0];
  assign jump_bad      = 1'b0;
  assign jump_tgt      = {bus.pc_next_i[XLEN-1:2], 2'b00};
  assign fetch_block   = 1'b0;
`endif

  assign jump_ok = bus.jump_valid_i && !jump_bad;

  // Responses still owed to us (live) reserve FIFO slots before the request goes out.
  assign credit_used = {1'b0, fifo_count} + {1'b0, outstanding} - {1'b0, discard};
  assign bus.mem_req_valid_o = !fetch_block
                            && (credit_used < (CNT_W+1)'(FIFO_DEPTH))
                            && (outstanding < CNT_W'(MAX_OUTSTANDING));
  assign bus.mem_req_addr_o  = fetch_pc;

  assign req_hs   = bus.mem_req_valid_o && bus.mem_req_ready_i;
  assign out_nxt  = outstanding + CNT_W'(req_hs) - CNT_W'(bus.mem_rsp_valid_i);
  assign rsp_push = bus.mem_rsp_valid_i && (discard == '0) && !bus.jump_valid_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      outstanding <= out_nxt;
      if (jump_ok) begin
        fetch_pc <= jump_tgt;
        rsp_pc   <= jump_tgt;
      end else begin
        if (req_hs)   fetch_pc <= fetch_pc + XLEN'(4);
        if (rsp_push) rsp_pc   <= rsp_pc + XLEN'(4);
      end
      // Everything still in flight after this cycle belongs to the abandoned stream.
      if (bus.jump_valid_i)
        discard <= out_nxt;
      else if (bus.mem_rsp_valid_i && (discard != '0))
        discard <= discard - 1'b1;
    end
  end

  ifu_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (rsp_push),
    .pop   (bus.instr_valid_o && bus.instr_ready_i),
    .clear (bus.jump_valid_i),
    .wdata ({rsp_pc, bus.mem_rsp_data_i}),
    .rdata (head),
    .count (fifo_count),
    .full  (unused_fifo_full),
    .empty (fifo_empty)
  );

  assign bus.instr_valid_o = !fifo_empty;
  assign bus.instr_o       = fifo_empty ? XLEN'(NOP_INSTR) : head[XLEN-1:0];
  assign bus.instr_pc_o    = fifo_empty ? rsp_pc : head[EW-1:XLEN];

endmodule

// File: tb/tb_ifu_prefetch.sv
// Scoreboard bench for ifu_prefetch: SRAM model with fixed per-phase latency, sequential-stream reference.
module tb_ifu_prefetch;
  import ifu_prefetch_pkg::*;

  localparam int          FD     = 4;
  localparam int          MO     = 2;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
`ifdef IFU_MISALIGN_CHK_EN
  localparam bit CHK_EN = 1'b1;
  logic misalign_exc;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  ifu_prefetch_if #(.XLEN(32)) bus ();

  ifu_prefetch #(
    .XLEN(32), .FIFO_DEPTH(FD), .MAX_OUTSTANDING(MO), .RESET_PC(RST_PC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef IFU_MISALIGN_CHK_EN
    , .misalign_exc_o (misalign_exc)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int n_deliv = 0;
  int cyc = 0;
  int lat = 1;

  typedef struct {
    int          due;
    logic [31:0] addr;
  } pend_t;
  pend_t        sram_q[$];
  fetch_entry_t exp_q[$];
  logic [31:0]  exp_next;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
  endfunction

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference stream: after reset or a jump, instructions follow at pc, pc+4, ... with SRAM contents.
  task automatic exp_fill();
    while (exp_q.size() < 16) begin
      exp_q.push_back('{pc: exp_next, instr: mem_fn(exp_next)});
      exp_next += 32'd4;
    end
  endtask

  task automatic exp_seed(input logic [31:0] pc);
    exp_q.delete();
    exp_next = pc;
    exp_fill();
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // SRAM: accepted requests answered exactly lat cycles later, in order.
  always @(negedge clk) begin
    if (rst_n && bus.mem_req_valid_o && bus.mem_req_ready_i) begin
      check("inflight_limit", 72'((sram_q.size() + (bus.mem_rsp_valid_i ? 1 : 0) + 1) <= MO), 72'd1);
      check("req_addr_align", 72'(bus.mem_req_addr_o[1:0]), 72'd0);
      sram_q.push_back('{due: cyc + lat, addr: bus.mem_req_addr_o});
    end
  end

  always @(posedge clk) begin
    pend_t p;
    #1;
    bus.mem_rsp_valid_i = 1'b0;
    bus.mem_rsp_data_i  = $urandom;
    if (!rst_n) sram_q.delete();
    else if (sram_q.size() > 0 && sram_q[0].due <= cyc) begin
      p = sram_q.pop_front();
      bus.mem_rsp_valid_i = 1'b1;
      bus.mem_rsp_data_i  = mem_fn(p.addr);
    end
  end

  // Monitor: compares every delivered instruction against the reference stream.
  logic         jump_prev = 1'b0;
  logic         hold_prev = 1'b0;
  logic         exp_exc = 1'b0;
  fetch_entry_t held;
  always @(negedge clk) begin
    fetch_entry_t e;
    if (!rst_n) begin
      jump_prev = 1'b0;
      hold_prev = 1'b0;
      exp_exc   = 1'b0;
    end else begin
      if (jump_prev) check("valid_after_jump", 72'(bus.instr_valid_o), 72'd0);
      if (hold_prev)
        check("hold_stable", 72'({bus.instr_valid_o, bus.instr_pc_o, bus.instr_o}), 72'({1'b1, held}));
      if (!bus.instr_valid_o) check("nop_when_idle", 72'(bus.instr_o), 72'(NOP_INSTR));
`ifdef IFU_MISALIGN_CHK_EN
      check("misalign_flag", 72'(misalign_exc), 72'(exp_exc));
      if (exp_exc) check("no_fetch_misaligned", 72'(bus.mem_req_valid_o), 72'd0);
`endif
      if (bus.instr_valid_o && bus.instr_ready_i && !bus.jump_valid_i) begin
        n_deliv++;
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_delivery: got pc %0h, expected no instruction", bus.instr_pc_o);
        end else begin
          e = exp_q.pop_front();
          check("instr_pc", 72'(bus.instr_pc_o), 72'(e.pc));
          check("instr_data", 72'(bus.instr_o), 72'(e.instr));
          exp_fill();
        end
      end
      hold_prev = bus.instr_valid_o && !bus.instr_ready_i && !bus.jump_valid_i;
      held      = '{pc: bus.instr_pc_o, instr: bus.instr_o};
      if (bus.jump_valid_i) exp_exc = CHK_EN && (bus.pc_next_i[1:0] != 2'b00);
      jump_prev = bus.jump_valid_i;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_jump(input logic [31:0] t);
    bus.jump_valid_i = 1'b1;
    bus.pc_next_i    = t;
    if (CHK_EN && t[1:0] != 2'b00) exp_q.delete();
    else exp_seed({t[31:2], 2'b00});
  endtask

  task automatic drain_and_set_lat(input int l);
    bus.mem_req_ready_i = 1'b0;
    for (int k = 0; k < 50 && sram_q.size() != 0; k++) step();
    step();
    check("sram_drain", 72'(sram_q.size()), 72'd0);
    lat = l;
    bus.mem_req_ready_i = 1'b1;
  endtask

  initial begin
    int d0;
    logic [31:0] t;
    bus.mem_req_ready_i = 1'b1;
    bus.jump_valid_i    = 1'b0;
    bus.pc_next_i       = '0;
    bus.instr_ready_i   = 1'b0;
    exp_seed(RST_PC);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_instr_valid", 72'(bus.instr_valid_o), 72'd0);
    check("rst_instr", 72'(bus.instr_o), 72'(NOP_INSTR));
    check("rst_instr_pc", 72'(bus.instr_pc_o), 72'(RST_PC));
    step();
    rst_n = 1'b1;
    @(negedge clk);
    check("first_req_valid", 72'(bus.mem_req_valid_o), 72'd1);
    check("first_req_addr", 72'(bus.mem_req_addr_o), 72'(RST_PC));

    // Backpressure: FIFO fills, fetch stops, head holds at reset pc.
    repeat (10) step();
    @(negedge clk);
    check("full_stalls_fetch", 72'(bus.mem_req_valid_o), 72'd0);
    check("head_pc_held", 72'(bus.instr_pc_o), 72'(RST_PC));
    check("head_data_held", 72'(bus.instr_o), 72'(mem_fn(RST_PC)));

    // Release and measure steady-state throughput with a zero-wait SRAM.
    step();
    bus.instr_ready_i = 1'b1;
    repeat (10) step();
    d0 = n_deliv;
    repeat (30) step();
    check("throughput_30", 72'(n_deliv - d0), 72'd30);

    // Three-cycle latency, then a jump with requests in flight.
    drain_and_set_lat(3);
    repeat (30) step();
    set_jump(32'h0000_0100);
    step();
    bus.jump_valid_i = 1'b0;
    d0 = n_deliv;
    repeat (25) step();
    check("jump_0x100_progress", 72'(n_deliv > d0), 72'd1);

    // Jump coinciding with response and pop, then an immediate second jump.
    drain_and_set_lat(1);
    repeat (10) step();
    set_jump(32'h0000_0300);
    step();
    set_jump(32'h0000_0200);
    step();
    bus.jump_valid_i = 1'b0;
    d0 = n_deliv;
    repeat (20) step();
    check("back_to_back_progress", 72'(n_deliv - d0 >= 15), 72'd1);

`ifdef IFU_MISALIGN_CHK_EN
    set_jump(32'h0000_0102);
    step();
    bus.jump_valid_i = 1'b0;
    repeat (5) step();
    @(negedge clk);
    check("misalign_set", 72'(misalign_exc), 72'd1);
    check("misalign_no_req", 72'(bus.mem_req_valid_o), 72'd0);
    check("misalign_empty", 72'(bus.instr_valid_o), 72'd0);
    step();
    set_jump(32'h0000_0200);
    step();
    bus.jump_valid_i = 1'b0;
    d0 = n_deliv;
    repeat (15) step();
    @(negedge clk);
    check("misalign_cleared", 72'(misalign_exc), 72'd0);
    check("misalign_resume", 72'(n_deliv > d0), 72'd1);
`endif

    // Randomised traffic with occasional latency changes and one mid-run reset.
    for (int i = 0; i < 1500; i++) begin
      step();
      if (i % 300 == 150) drain_and_set_lat(int'($urandom_range(1, 3)));
      if (i == 700) begin
        bus.jump_valid_i = 1'b0;
        rst_n = 1'b0;
        exp_seed(RST_PC);
        step();
        step();
        rst_n = 1'b1;
      end
      bus.mem_req_ready_i = ($urandom_range(0, 9) < 7);
      bus.instr_ready_i   = ($urandom_range(0, 9) < 6);
      if ($urandom_range(0, 99) < 4) begin
        t = $urandom;
        if (CHK_EN) begin
          t[1:0] = 2'b00;
          if ($urandom_range(0, 3) == 0) t[1:0] = 2'($urandom_range(1, 3));
        end
        set_jump(t);
      end else begin
        bus.jump_valid_i = 1'b0;
      end
    end
    step();
    bus.jump_valid_i = 1'b0;
    repeat (5) step();
    check("total_deliveries", 72'(n_deliv > 300), 72'd1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
